// File: rtl/ved_mul_arbiter.sv
// Round-robin arbiter that shares one combinational 8x8 unsigned multiplier among
// NREQ valid/ready requesters and presents each tagged product until it is accepted.

module ved_8x8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    assign p_o = 16'(a_i) * 16'(b_i);
endmodule

module ved_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_result,
    output logic [IDW-1:0]      out_id,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     out_result_q, out_result_d;
    logic [IDW-1:0]  out_id_q, out_id_d;

    logic [7:0]      a_slice [NREQ];
    logic [7:0]      b_slice [NREQ];
    logic [NREQ-1:0] upper_req;
    logic [NREQ-1:0] grant_onehot;
    logic            grant_found;
    logic            use_upper;
    logic [IDW-1:0]  grant_idx;
    logic [15:0]     product;

    // upper_req holds requesters at or above the pointer; if none, wrap to the lowest index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign a_slice[gi]      = req_a[8*gi +: 8];
        assign b_slice[gi]      = req_b[8*gi +: 8];
        assign upper_req[gi]    = req_valid[gi] && (IDW'(gi) >= rr_ptr_q);
        assign grant_onehot[gi] = grant_found && (grant_idx == IDW'(gi));
    end

    always_comb begin
        grant_found = |req_valid;
        use_upper   = |upper_req;
        grant_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (use_upper ? upper_req[j] : req_valid[j]) begin
                grant_idx = IDW'(j);
            end
        end
    end

    ved_8x8 u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (product)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_id_d     = out_id_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d   = a_slice[grant_idx];
                    op_b_d   = b_slice[grant_idx];
                    op_id_d  = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                out_result_d = product;
                out_id_d     = op_id_q;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
        end
    end

    // Grant is combinational so a requester sees ready in the same IDLE cycle it is chosen.
    assign req_ready  = (state_q == IDLE && !rst) ? grant_onehot : '0;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/ved_mul_arbiter.md
# ved_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `ved_8x8` multiplier among `NREQ` requesters. Each requester presents an 8x8 unsigned operand pair with a valid/ready handshake. The block grants one requester at a time and registers the operands. It then computes the 16-bit product through the shared multiplier, registers it, and holds it on a single tagged result port until the consumer accepts it. It sits between the multiplier datapath and the client blocks that need products.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 2: requester-ID width; must be at least ceil(log2(NREQ)).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in `NREQ`: bit i high means requester i presents operands.
- `req_a` in 8*`NREQ`: multiplicand; requester i occupies bits [8i+7:8i].
- `req_b` in 8*`NREQ`: multiplier; same packing as `req_a`.
- `req_ready` out `NREQ`: one-hot grant. Handshake for requester i completes in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `out_valid` out 1: `out_result` and `out_id` are valid.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 16: unsigned product a*b.
- `out_id` out `IDW`: index of the requester that owns `out_result`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - CALC: operands latched; multiplier evaluating.
  - HOLD: result presented on the output port.
- IDLE:
  - If any `req_valid` bit is high, grant the first set bit found scanning from `rr_ptr` upward, wrapping modulo `NREQ`.
  - `req_ready[g]` is high combinationally in that cycle.
  - At the clock edge: latch `op_a`/`op_b` from slice g, set `op_id` = g, set `rr_ptr` = (g+1) mod `NREQ`, go to CALC.
  - If no `req_valid` bit is high, stay in IDLE; `req_ready` stays all-zero.
- CALC:
  - `out_result` <= `ved_8x8`(`op_a`, `op_b`); `out_id` <= `op_id`; `out_valid` <= 1.
  - Go to HOLD.
- HOLD:
  - `out_valid` stays high; `out_result` and `out_id` are held stable.
  - On `out_ready`=1: `out_valid` <= 0 and go to IDLE.
- `req_ready` is all-zero outside IDLE and during `rst`.
- Requesters must hold `req_valid` and their operands until granted. A requester that drops `req_valid` before its grant is skipped without error.
- `rr_ptr` advances only on a grant, so the most recently served requester gets lowest priority on the next arbitration.
- Arithmetic:
  - Unsigned and exact; all 16 result bits are significant.
  - No truncation or overflow path. 0xFF*0xFF = 0xFE01.
- Reset values:
  - State IDLE; `rr_ptr`=0; `op_a`=`op_b`=0; `op_id`=0.
  - `out_valid`=0; `out_result`=0x0000; `out_id`=0; `busy`=0; `req_ready`=0.
- Reset during CALC or HOLD aborts the operation; the pending result is discarded and never presented.
- `rst` takes priority over every other event in the same cycle.

## Timing
- Grant at edge T (cycle with `req_ready` high). `out_valid` rises after edge T+2, i.e. two cycles of latency.
- The minimum service interval is 3 cycles per product: one each in IDLE, CALC and HOLD with `out_ready` held at 1.
- The path `op_a`/`op_b` -> `ved_8x8` -> `out_result` register is one full cycle; no other logic is in series.
- `req_ready` depends combinationally on `req_valid`, state and `rr_ptr` only. It never depends on `out_ready`.
- The block tolerates `out_ready` high while `out_valid` is low; this has no effect.
- In HOLD, new requests wait. They are arbitered in the first IDLE cycle after acceptance.

## Test plan
- Reset: assert `rst` for 2 cycles with all `req_valid`=1. All outputs hold their reset values, `req_ready`=0, and `busy`=0 throughout.
- Single request: requester 2 presents a=0x0C, b=0x0D. `req_ready`=0b0100 for one cycle; two cycles later `out_valid`=1 with `out_result`=0x009C and `out_id`=2.
- Fairness: all four requesters hold valid continuously with `out_ready`=1. The grant order is 0,1,2,3,0,1. Each grant is 3 cycles apart, and each `out_id` matches its grant.
- Backpressure: a=0xFF, b=0xFF with `out_ready`=0 for 5 cycles. `out_result`=0xFE01 and `out_id` stay stable, and `req_ready` stays 0 despite pending requests. Raising `out_ready` returns the FSM to IDLE one cycle later.
- Reset mid-operation: pulse `rst` in the CALC cycle. `out_valid` never rises for that request, and the next grant starts from requester 0.
- Exhaustive: sweep all 65536 a,b pairs through requester 1. Every `out_result` equals a*b.
